// File: rtl/segment_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : segment_load_controller
// Purpose  : Sequences the load of one segment register. In real mode it
//            synthesizes a descriptor from the selector. In protected mode it
//            walks the GDT/LDT, reads the 8-byte descriptor and runs the
//            80386 load-time checks. It can write the Accessed bit back to
//            memory, and then commits the selector and descriptor to the
//            segment register file.
// Ports    : clock/reset            - clock, async active-high reset
//            i_load_* / o_load_ready - request handshake from execute
//            i_protected_mode, i_current_privilege_level - mode / CPL
//            i_gdtr_*, i_ldtr_*      - descriptor table base / limit
//            o_mem_read_*, i_mem_*   - descriptor read port (to BIU)
//            o_mem_write_*           - Accessed-bit write-back (to BIU)
//            o_segment_*             - segment register file write port
//            o_done/o_fault/o_fault_* - completion pulse and fault report
// Revision : 1.0 - initial release
// ============================================================================
module segment_load_controller #(
  parameter bit SET_ACCESSED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load_valid,
  output logic        o_load_ready,
  input  logic [2:0]  i_load_segment_index,
  input  logic [15:0] i_load_selector,
  input  logic        i_protected_mode,
  input  logic [1:0]  i_current_privilege_level,
  input  logic [31:0] i_gdtr_base,
  input  logic [15:0] i_gdtr_limit,
  input  logic [31:0] i_ldtr_base,
  input  logic [31:0] i_ldtr_limit,
  output logic        o_mem_read_valid,
  input  logic        i_mem_read_ready,
  output logic [31:0] o_mem_address,
  input  logic        i_mem_data_valid,
  input  logic [31:0] i_mem_data,
  output logic        o_mem_write_valid,
  input  logic        i_mem_write_ready,
  output logic [31:0] o_mem_write_data,
  output logic        o_segment_write_enable,
  output logic [2:0]  o_segment_index,
  output logic [15:0] o_segment_selector,
  output logic [63:0] o_segment_descriptor,
  output logic        o_done,
  output logic        o_fault,
  output logic [7:0]  o_fault_vector,
  output logic [15:0] o_fault_error_code
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CHECK_SEL  = 4'd1,
    S_READ_LO    = 4'd2,
    S_WAIT_LO    = 4'd3,
    S_READ_HI    = 4'd4,
    S_WAIT_HI    = 4'd5,
    S_CHECK_DESC = 4'd6,
    S_WRITE_ACC  = 4'd7,
    S_COMMIT     = 4'd8,
    S_FAULT      = 4'd9
  } state_t;

  localparam logic [2:0] SEG_CS    = 3'd0;
  localparam logic [2:0] SEG_SS    = 3'd1;
  localparam logic [2:0] SEG_MAX   = 3'd5;
  localparam logic [7:0] VEC_GP    = 8'd13;
  localparam logic [7:0] VEC_NP    = 8'd11;
  localparam logic [7:0] VEC_SS    = 8'd12;

  // Latched request and working state
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sel_q, sel_d;
  logic [1:0]  cpl_q, cpl_d;
  logic [63:0] desc_q, desc_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  vec_d;
  logic [15:0] code_d;

  // Registered output decodes
  logic        rd_valid_q;
  logic        wr_valid_q;
  logic [31:0] wr_data_q;
  logic        seg_we_q;
  logic        done_q;
  logic        fault_q;
  logic [7:0]  vec_q;
  logic [15:0] code_q;

  // ---------------------------------------------------------------------------
  // Descriptor-table lookup for the latched selector
  // ---------------------------------------------------------------------------
  logic        sel_null;
  logic [31:0] tbl_base;
  logic [31:0] tbl_limit;
  logic [31:0] sel_last_byte;
  logic [31:0] sel_offset;
  logic [15:0] sel_err_code;

  // The table registers are architectural state that execute does not change
  // while a segment load is in flight, so they are read live here.
  assign sel_null      = (sel_q[15:2] == 14'd0);
  assign tbl_base      = sel_q[2] ? i_ldtr_base  : i_gdtr_base;
  assign tbl_limit     = sel_q[2] ? i_ldtr_limit : {16'd0, i_gdtr_limit};
  assign sel_last_byte = {16'd0, sel_q[15:3], 3'b111};
  assign sel_offset    = {16'd0, sel_q[15:3], 3'b000};
  assign sel_err_code  = {sel_q[15:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Real-mode descriptor: base = selector << 4, 64 KiB byte-granular limit,
  // present, DPL 0, code/data with the Accessed bit already set.
  // ---------------------------------------------------------------------------
  logic [31:0] rm_base;
  logic [3:0]  rm_type;
  logic [63:0] rm_desc;

  assign rm_base = {12'd0, i_load_selector, 4'd0};
  assign rm_type = (i_load_segment_index == SEG_CS) ? 4'b1011 : 4'b0011;
  assign rm_desc = {rm_base[31:24], 4'b0000, 4'h0, 1'b1, 2'b00, 1'b1, rm_type,
                    rm_base[23:16], rm_base[15:0], 16'hFFFF};

  // ---------------------------------------------------------------------------
  // Load-time protection checks on the fetched descriptor
  // ---------------------------------------------------------------------------
  logic       d_present;
  logic [1:0] d_dpl;
  logic       d_sys;
  logic       d_exec;
  logic       d_conf;
  logic       d_rw;
  logic [1:0] rpl;
  logic [1:0] eff_pl;
  logic       chk_fault;
  logic [7:0] chk_vec;

  assign d_present = desc_q[47];
  assign d_dpl     = desc_q[46:45];
  assign d_sys     = desc_q[44];
  assign d_exec    = desc_q[43];
  assign d_conf    = desc_q[42];
  assign d_rw      = desc_q[41];
  assign rpl       = sel_q[1:0];
  assign eff_pl    = (cpl_q > rpl) ? cpl_q : rpl;

  always_comb begin
    chk_fault = 1'b0;
    chk_vec   = VEC_GP;
    if (!d_sys) begin
      chk_fault = 1'b1;
    end else if (idx_q == SEG_CS) begin
      if (!d_exec) begin
        chk_fault = 1'b1;
      end else if (d_conf ? (d_dpl > cpl_q) : (d_dpl != cpl_q)) begin
        chk_fault = 1'b1;
      end else if (!d_present) begin
        chk_fault = 1'b1;
        chk_vec   = VEC_NP;
      end
    end else if (idx_q == SEG_SS) begin
      if (d_exec || !d_rw || (rpl != cpl_q) || (d_dpl != cpl_q)) begin
        chk_fault = 1'b1;
      end else if (!d_present) begin
        chk_fault = 1'b1;
        chk_vec   = VEC_SS;
      end
    end else begin
      // Conforming readable code is exempt from the privilege test.
      if (d_exec && !d_rw) begin
        chk_fault = 1'b1;
      end else if ((!d_exec || !d_conf) && (d_dpl < eff_pl)) begin
        chk_fault = 1'b1;
      end else if (!d_present) begin
        chk_fault = 1'b1;
        chk_vec   = VEC_NP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cpl_d   = cpl_q;
    desc_d  = desc_q;
    addr_d  = addr_q;
    vec_d   = 8'd0;
    code_d  = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (i_load_valid) begin
          idx_d = i_load_segment_index;
          sel_d = i_load_selector;
          cpl_d = i_current_privilege_level;
          if (i_load_segment_index > SEG_MAX) begin
            state_d = S_FAULT;
            vec_d   = VEC_GP;
          end else if (!i_protected_mode) begin
            state_d = S_COMMIT;
            desc_d  = rm_desc;
          end else begin
            state_d = S_CHECK_SEL;
          end
        end
      end

      S_CHECK_SEL: begin
        if (sel_null) begin
          if ((idx_q == SEG_CS) || (idx_q == SEG_SS)) begin
            state_d = S_FAULT;
            vec_d   = VEC_GP;
          end else begin
            // A null data selector is legal; it loads an unusable segment.
            state_d = S_COMMIT;
            desc_d  = 64'd0;
          end
        end else if (sel_last_byte > tbl_limit) begin
          state_d = S_FAULT;
          vec_d   = VEC_GP;
          code_d  = sel_err_code;
        end else begin
          state_d = S_READ_LO;
          addr_d  = tbl_base + sel_offset;
        end
      end

      S_READ_LO: begin
        if (i_mem_read_ready) begin
          state_d = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (i_mem_data_valid) begin
          desc_d[31:0] = i_mem_data;
          addr_d       = addr_q + 32'd4;
          state_d      = S_READ_HI;
        end
      end

      S_READ_HI: begin
        if (i_mem_read_ready) begin
          state_d = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        if (i_mem_data_valid) begin
          desc_d[63:32] = i_mem_data;
          state_d       = S_CHECK_DESC;
        end
      end

      S_CHECK_DESC: begin
        if (chk_fault) begin
          state_d = S_FAULT;
          vec_d   = chk_vec;
          code_d  = sel_err_code;
        end else if (!desc_q[40] && SET_ACCESSED) begin
          // The address still points at the high dword, which holds bit 40.
          state_d    = S_WRITE_ACC;
          desc_d[40] = 1'b1;
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_WRITE_ACC: begin
        if (i_mem_write_ready) begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Outputs are decoded from the next state so
  // they line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      sel_q      <= 16'd0;
      cpl_q      <= 2'd0;
      desc_q     <= 64'd0;
      addr_q     <= 32'd0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 32'd0;
      seg_we_q   <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      vec_q      <= 8'd0;
      code_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      cpl_q      <= cpl_d;
      desc_q     <= desc_d;
      addr_q     <= addr_d;
      rd_valid_q <= (state_d == S_READ_LO) || (state_d == S_READ_HI);
      wr_valid_q <= (state_d == S_WRITE_ACC);
      wr_data_q  <= (state_d == S_WRITE_ACC) ? desc_d[63:32] : 32'd0;
      seg_we_q   <= (state_d == S_COMMIT);
      done_q     <= (state_d == S_COMMIT) || (state_d == S_FAULT);
      fault_q    <= (state_d == S_FAULT);
      vec_q      <= vec_d;
      code_q     <= code_d;
    end
  end

  assign o_load_ready           = (state_q == S_IDLE);
  assign o_mem_read_valid       = rd_valid_q;
  assign o_mem_address          = addr_q;
  assign o_mem_write_valid      = wr_valid_q;
  assign o_mem_write_data       = wr_data_q;
  assign o_segment_write_enable = seg_we_q;
  assign o_segment_index        = idx_q;
  assign o_segment_selector     = sel_q;
  assign o_segment_descriptor   = desc_q;
  assign o_done                 = done_q;
  assign o_fault                = fault_q;
  assign o_fault_vector         = vec_q;
  assign o_fault_error_code     = code_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_load_controller
// Purpose  : Directed bench for segment_load_controller. Expected responses
//            are queued at issue time. A monitor pops and compares them on
//            each o_done. A memory responder serves and checks descriptor
//            reads and Accessed write-backs against a queue of expected
//            transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_load_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_load_valid = 1'b0;
  logic        o_load_ready;
  logic [2:0]  i_load_segment_index = 3'd0;
  logic [15:0] i_load_selector = 16'd0;
  logic        i_protected_mode = 1'b0;
  logic [1:0]  i_current_privilege_level = 2'd0;
  logic [31:0] i_gdtr_base = 32'h0000_1000;
  logic [15:0] i_gdtr_limit = 16'h0017;
  logic [31:0] i_ldtr_base = 32'h0000_2000;
  logic [31:0] i_ldtr_limit = 32'h0000_000F;
  logic        o_mem_read_valid;
  logic        i_mem_read_ready = 1'b0;
  logic [31:0] o_mem_address;
  logic        i_mem_data_valid = 1'b0;
  logic [31:0] i_mem_data = 32'd0;
  logic        o_mem_write_valid;
  logic        i_mem_write_ready = 1'b0;
  logic [31:0] o_mem_write_data;
  logic        o_segment_write_enable;
  logic [2:0]  o_segment_index;
  logic [15:0] o_segment_selector;
  logic [63:0] o_segment_descriptor;
  logic        o_done;
  logic        o_fault;
  logic [7:0]  o_fault_vector;
  logic [15:0] o_fault_error_code;

  segment_load_controller #(.SET_ACCESSED(1'b1)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .i_load_valid              (i_load_valid),
    .o_load_ready              (o_load_ready),
    .i_load_segment_index      (i_load_segment_index),
    .i_load_selector           (i_load_selector),
    .i_protected_mode          (i_protected_mode),
    .i_current_privilege_level (i_current_privilege_level),
    .i_gdtr_base               (i_gdtr_base),
    .i_gdtr_limit              (i_gdtr_limit),
    .i_ldtr_base               (i_ldtr_base),
    .i_ldtr_limit              (i_ldtr_limit),
    .o_mem_read_valid          (o_mem_read_valid),
    .i_mem_read_ready          (i_mem_read_ready),
    .o_mem_address             (o_mem_address),
    .i_mem_data_valid          (i_mem_data_valid),
    .i_mem_data                (i_mem_data),
    .o_mem_write_valid         (o_mem_write_valid),
    .i_mem_write_ready         (i_mem_write_ready),
    .o_mem_write_data          (o_mem_write_data),
    .o_segment_write_enable    (o_segment_write_enable),
    .o_segment_index           (o_segment_index),
    .o_segment_selector        (o_segment_selector),
    .o_segment_descriptor      (o_segment_descriptor),
    .o_done                    (o_done),
    .o_fault                   (o_fault),
    .o_fault_vector            (o_fault_vector),
    .o_fault_error_code        (o_fault_error_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        fault;
    logic [7:0]  vec;
    logic [15:0] code;
    logic [63:0] desc;
    logic [2:0]  idx;
    logic [15:0] sel;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
    bit          stall;
  } mem_t;

  exp_t sb[$];
  mem_t memq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   inject_late = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic mrd(input logic [31:0] a, input logic [31:0] d, input int dly, input bit stall);
    mem_t m;
    m.wr = 1'b0; m.addr = a; m.data = d; m.dly = dly; m.stall = stall;
    memq.push_back(m);
  endtask

  task automatic mwr(input logic [31:0] a, input logic [31:0] d);
    mem_t m;
    m.wr = 1'b1; m.addr = a; m.data = d; m.dly = 0; m.stall = 1'b0;
    memq.push_back(m);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected response per o_done
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (o_done) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("fault", 64'(o_fault), 64'(e.fault));
          chk("seg_we", 64'(o_segment_write_enable), 64'(!e.fault));
          if (e.fault) begin
            chk("fault_vector", 64'(o_fault_vector), 64'(e.vec));
            chk("fault_code", 64'(o_fault_error_code), 64'(e.code));
          end else begin
            chk("seg_index", 64'(o_segment_index), 64'(e.idx));
            chk("seg_selector", 64'(o_segment_selector), 64'(e.sel));
            chk("seg_descriptor", o_segment_descriptor, e.desc);
          end
        end
      end else if (o_segment_write_enable) begin
        fail_now("seg_we_without_done");
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory responder: checks each request against memq, returns read data
  // one cycle after accepting the read.
  // ---------------------------------------------------------------------------
  initial begin
    mem_t        m;
    int          wait_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = 32'd0;
    forever begin
      @(negedge clock);
      i_mem_read_ready  = 1'b0;
      i_mem_write_ready = 1'b0;
      i_mem_data_valid  = 1'b0;
      if (pend) begin
        i_mem_data_valid = 1'b1;
        i_mem_data       = pend_data;
        pend             = 1'b0;
      end else if (inject_late) begin
        i_mem_data_valid = 1'b1;
        i_mem_data       = 32'h00CF_9300;
        inject_late      = 1'b0;
      end
      if (o_mem_read_valid || o_mem_write_valid) begin
        if (memq.size() == 0) begin
          fail_now("unexpected_mem_traffic");
          i_mem_read_ready  = o_mem_read_valid;
          i_mem_write_ready = o_mem_write_valid;
        end else if (wait_cnt < memq[0].dly) begin
          wait_cnt++;
        end else begin
          m = memq.pop_front();
          wait_cnt = 0;
          chk("mem_is_write", 64'(o_mem_write_valid), 64'(m.wr));
          chk("mem_address", 64'(o_mem_address), 64'(m.addr));
          if (m.wr) begin
            chk("mem_write_data", 64'(o_mem_write_data), 64'(m.data));
            i_mem_write_ready = 1'b1;
          end else begin
            i_mem_read_ready = 1'b1;
            if (!m.stall) begin
              pend      = 1'b1;
              pend_data = m.data;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one load, queue its expected response and wait for completion.
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic pm, input logic [1:0] cpl, input logic [2:0] idx,
                         input logic [15:0] sel, input logic flt, input logic [7:0] vec,
                         input logic [15:0] code, input logic [63:0] desc, input int lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    while (!o_load_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!o_load_ready) fail_now("ready_timeout");
    e.fault = flt; e.vec = vec; e.code = code; e.desc = desc;
    e.idx = idx; e.sel = sel; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    i_load_valid              = 1'b1;
    i_protected_mode          = pm;
    i_current_privilege_level = cpl;
    i_load_segment_index      = idx;
    i_load_selector           = sel;
    @(negedge clock);
    i_load_valid = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      fail_now("done_timeout");
      sb.delete();
    end
    chk("mem_queue_drained", 64'(memq.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_load_ready", 64'(o_load_ready), 64'd1);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_mem_read_valid", 64'(o_mem_read_valid), 64'd0);
    chk("rst_mem_address", 64'(o_mem_address), 64'd0);
    chk("rst_descriptor", o_segment_descriptor, 64'd0);

    // Real mode
    do_load(1'b0, 2'd0, 3'd2, 16'h1234, 1'b0, 8'd0, 16'd0, 64'h0000_9301_2340_FFFF, 1);
    do_load(1'b0, 2'd0, 3'd0, 16'hF000, 1'b0, 8'd0, 16'd0, 64'h0000_9B0F_0000_FFFF, 1);

    // Protected, GDT, Accessed already set
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_9300, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd2, 16'h0010, 1'b0, 8'd0, 16'd0, 64'h00CF_9300_0000_FFFF, 7);

    // Accessed clear: write-back of the high dword with bit 40 set
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_9200, 0, 1'b0);
    mwr(32'h1014, 32'h00CF_9300);
    do_load(1'b1, 2'd0, 3'd2, 16'h0010, 1'b0, 8'd0, 16'd0, 64'h00CF_9300_0000_FFFF, 8);

    // Limit fault, null selectors, illegal index
    do_load(1'b1, 2'd0, 3'd2, 16'h0018, 1'b1, 8'd13, 16'h0018, 64'd0, 2);
    do_load(1'b1, 2'd0, 3'd1, 16'h0000, 1'b1, 8'd13, 16'h0000, 64'd0, 2);
    do_load(1'b1, 2'd0, 3'd2, 16'h0003, 1'b0, 8'd0, 16'd0, 64'd0, 2);
    do_load(1'b1, 2'd0, 3'd6, 16'h0010, 1'b1, 8'd13, 16'h0000, 64'd0, 1);

    // SS with DPL 3 at CPL 0
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_F300, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd1, 16'h0010, 1'b1, 8'd13, 16'h0010, 64'd0, 7);

    // DS not present
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_1300, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd2, 16'h0010, 1'b1, 8'd11, 16'h0010, 64'd0, 7);

    // SS not present, privileges matching
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_1300, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd1, 16'h0010, 1'b1, 8'd12, 16'h0010, 64'd0, 7);

    // CS from LDT at the table limit, with a two-cycle read stall
    mrd(32'h2008, 32'h0000_FFFF, 2, 1'b0);
    mrd(32'h200C, 32'h00CF_9B00, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd0, 16'h000C, 1'b0, 8'd0, 16'd0, 64'h00CF_9B00_0000_FFFF, 9);

    // Reset while waiting for the high dword, then a late data return
    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_9300, 0, 1'b1);
    @(negedge clock);
    i_load_valid         = 1'b1;
    i_protected_mode     = 1'b1;
    i_load_segment_index = 3'd2;
    i_load_selector      = 16'h0010;
    @(negedge clock);
    i_load_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("stall_not_ready", 64'(o_load_ready), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    inject_late = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_ready", 64'(o_load_ready), 64'd1);
    chk("post_reset_seg_we", 64'(o_segment_write_enable), 64'd0);
    chk("post_reset_descriptor", o_segment_descriptor, 64'd0);
    chk("post_reset_mem_read_valid", 64'(o_mem_read_valid), 64'd0);
    chk("post_reset_mem_queue", 64'(memq.size()), 64'd0);

    mrd(32'h1010, 32'h0000_FFFF, 0, 1'b0);
    mrd(32'h1014, 32'h00CF_9300, 0, 1'b0);
    do_load(1'b1, 2'd0, 3'd2, 16'h0010, 1'b0, 8'd0, 16'd0, 64'h00CF_9300_0000_FFFF, 7);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_load_controller.md
# segment_load_controller

Sequences loading of one segment register: takes a selector and target index, walks GDT/LDT in protected mode or synthesizes a real-mode descriptor, runs the 80386 load-time checks, sets the descriptor Accessed bit in memory, and commits selector and 64-bit descriptor into the segment register file consumed by `segmentation_unit`. Sits between execute (requester) and the bus interface unit (descriptor memory port). Handles one load at a time.

## Interface
- `SET_ACCESSED`, default 1: when 1, a descriptor read with Accessed=0 is written back with bit 40 set before commit.
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `i_load_valid` in 1: load request.
- `o_load_ready` out 1: high only in IDLE.
- `i_load_segment_index` in 3: 0=CS, 1=SS, 2=DS, 3=ES, 4=FS, 5=GS; 6/7 are illegal.
- `i_load_selector` in 16: selector (index[15:3], TI[2], RPL[1:0]).
- `i_protected_mode` in 1: CR0.PE, sampled at accept.
- `i_current_privilege_level` in 2: CPL, sampled at accept.
- `i_gdtr_base` in 32, `i_gdtr_limit` in 16: GDT.
- `i_ldtr_base` in 32, `i_ldtr_limit` in 32: LDT, byte-granular limit.
- `o_mem_read_valid` out 1, `i_mem_read_ready` in 1, `o_mem_address` out 32: read request.
- `i_mem_data_valid` in 1, `i_mem_data` in 32: read data return.
- `o_mem_write_valid` out 1, `i_mem_write_ready` in 1, `o_mem_write_data` out 32: Accessed write-back; uses `o_mem_address`.
- `o_segment_write_enable` out 1, `o_segment_index` out 3, `o_segment_selector` out 16, `o_segment_descriptor` out 64: register-file write port.
- `o_done` out 1: one-cycle completion pulse.
- `o_fault` out 1: qualifies `o_done`; load was rejected.
- `o_fault_vector` out 8: 13 (#GP), 11 (#NP), 12 (#SS).
- `o_fault_error_code` out 16: `{selector[15:2],2'b00}`, or 0 for null-selector faults.

## Operation
- States: IDLE, CHECK_SEL, READ_LO, WAIT_LO, READ_HI, WAIT_HI, CHECK_DESC, WRITE_ACC, COMMIT, FAULT.
- IDLE: on `i_load_valid & o_load_ready`, latch all request inputs. Illegal index goes to FAULT #GP(0).
  - Real mode goes to COMMIT with a synthesized descriptor: base=`{12'b0,selector,4'b0}`, limit=0xFFFF, G=0, P=1, DPL=0, S=1.
  - Synthesized type: 1011 (code, readable, accessed) for CS; 0011 (data, RW, accessed) otherwise.
  - Protected mode goes to CHECK_SEL.
- CHECK_SEL:
  - Null selector means index=0 and TI=0.
    - For CS or SS: FAULT #GP(0).
    - Otherwise: COMMIT with descriptor 0 and no fault.
  - Table is LDT if TI=1, else GDT.
  - If `{selector[15:3],3'b111}` > limit: FAULT #GP(sel).
  - Else `o_mem_address` = base + `{selector[15:3],3'b000}` (32-bit wrap), then READ_LO.
- READ_LO: hold `o_mem_read_valid`=1 and the address until `i_mem_read_ready`, then WAIT_LO. WAIT_LO captures `i_mem_data` into descriptor[31:0] on `i_mem_data_valid`. `i_mem_data_valid` is ignored outside WAIT_LO/WAIT_HI.
- READ_HI / WAIT_HI: same sequence at address+4, capturing descriptor[63:32].
- CHECK_DESC: checks in priority order; the first failure goes to FAULT.
  - S (bit 44)=0: #GP(sel).
  - CS:
    - Must be executable (bit 43), else #GP(sel).
    - Nonconforming requires DPL==CPL; conforming requires DPL<=CPL. Failure is #GP(sel).
  - SS:
    - Must be writable data, with RPL==CPL and DPL==CPL, else #GP(sel).
    - P=0: #SS(sel).
  - DS/ES/FS/GS:
    - Execute-only code (executable, R=0): #GP(sel).
    - For data or nonconforming code, DPL >= max(CPL,RPL) is required, else #GP(sel).
  - P=0, all except SS: #NP(sel).
  - Pass with Accessed=0 and SET_ACCESSED=1: WRITE_ACC. Otherwise COMMIT.
- WRITE_ACC:
  - Set descriptor bit 40 in the latched copy.
  - Drive `o_mem_write_valid`=1, address+4, and `o_mem_write_data`=descriptor[63:32] until `i_mem_write_ready`, then COMMIT.
- COMMIT:
  - `o_segment_write_enable`=1 with index, selector and descriptor.
  - `o_done`=1, `o_fault`=0. Next state IDLE.
- FAULT: `o_done`=1, `o_fault`=1, vector and error code valid, no register write. Next state IDLE.

## Timing
- Reset: state IDLE. `o_load_ready`=1. All other outputs 0, including the latched descriptor.
- Reset asserted mid-operation: the load is dropped with no write and no `o_done`. Late memory responses are ignored in IDLE.
- `o_load_ready` is combinational from state. A new request is accepted the cycle after `o_done`.
- All other outputs are registered state decodes. Valid/write pulses last exactly one cycle.
- Accept at cycle T.
  - Real mode: COMMIT at T+1.
  - Null or limit fault: COMMIT/FAULT at T+2.
  - Zero-wait memory (ready at once, data the cycle after acceptance), Accessed=1: READ_LO T+2, WAIT_LO T+3, READ_HI T+4, WAIT_HI T+5, CHECK_DESC T+6, COMMIT T+7.
  - Zero-wait memory with Accessed=0: WRITE_ACC T+7, COMMIT T+8.
- Memory stalls extend the request states with no timeout. The address is stable while valid is high.
- Limit compare is 32-bit unsigned, with the GDT limit zero-extended.

## Test plan
- Real mode, DS, selector 0x1234 -> done at T+1, base 0x00012340, limit 0xFFFF, type 0011, no fault.
- Protected, CPL0, DS sel 0x0010, GDT base 0x1000, limit 0x17, descriptor {0x00CF9300,0x0000FFFF} -> reads 0x1010 and 0x1014, commit at T+7, no write-back.
- Same as above with descriptor high word 0x00CF9200 -> write 0x00CF9300 to 0x1014, commit at T+8 with bit 40 set.
- Sel 0x0018 with GDT limit 0x17 -> #GP, code 0x0018, no memory traffic. SS null -> #GP(0). DS null -> commit zero descriptor.
- SS load with DPL=3, CPL=0 -> #GP(sel). DS load with P=0 -> #NP(sel). SS load with P=0 and privileges matching -> #SS(sel).
- Reset asserted while in WAIT_HI, then data returns -> no write, no done, `o_load_ready`=1. Next request completes normally.
